// File: rtl/alu_cmd_if.sv
// Bundle for the ALU command sequencer: command push, ALU drive/return, result
// pop and status. The sequencer uses the slave view; upstream/downstream use master.
interface alu_cmd_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;

  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_out;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [2:0]       res_op;

  logic [CW-1:0]    fifo_count;
  logic             busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, res_ready,
    output cmd_ready, alu_op, alu_a, alu_b, res_valid, res_data, res_op,
           fifo_count, busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, res_ready,
    input  cmd_ready, alu_op, alu_a, alu_b, res_valid, res_data, res_op,
           fifo_count, busy
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands in a small FIFO, issues them one at a time to a
// combinational ALU and holds each captured result until the consumer takes it.
module alu_cmd_sequencer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic      clk,
  input logic      rst,
  alu_cmd_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;

  logic [2:0]       op_mem_q [DEPTH];
  logic [WIDTH-1:0] a_mem_q  [DEPTH];
  logic [WIDTH-1:0] b_mem_q  [DEPTH];

  logic [2:0]       alu_op_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic             res_valid_q;
  logic [WIDTH-1:0] res_data_q;
  logic [2:0]       res_op_q;

  logic push, pop, capture, res_take;

  // Full is judged on the registered count only; a same-cycle pop never frees a slot early.
  assign bus.cmd_ready = (count_q < CW'(DEPTH));
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign count_d       = count_q + CW'(push) - CW'(pop);

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    capture  = 1'b0;
    res_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        capture = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (bus.res_ready) begin
          res_take = 1'b1;
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem_q[wr_ptr_q] <= bus.cmd_op;
      a_mem_q[wr_ptr_q]  <= bus.cmd_a;
      b_mem_q[wr_ptr_q]  <= bus.cmd_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        alu_op_q <= op_mem_q[rd_ptr_q];
        alu_a_q  <= a_mem_q[rd_ptr_q];
        alu_b_q  <= b_mem_q[rd_ptr_q];
      end
      // The ALU has had a full cycle to settle on the operands issued last edge.
      if (capture) begin
        res_valid_q <= 1'b1;
        res_data_q  <= bus.alu_out;
        res_op_q    <= alu_op_q;
      end else if (res_take) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign bus.alu_op     = alu_op_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_op     = res_op_q;
  assign bus.fifo_count = count_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized bench for alu_cmd_sequencer: a queue-based reference tracks every
// accepted command and checks each consumed result in arrival order.
module tb_alu_cmd_sequencer;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_cmd_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd0:    return 32'd0;
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return {a[30:0], 1'b0};
      3'd4:    return {1'b0, a[31:1]};
      3'd5:    return a & b;
      3'd6:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Connected combinational ALU
  assign bus.alu_out = ref_alu(bus.alu_op, bus.alu_a, bus.alu_b);

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  cmd_t        send_q[$];
  cmd_t        exp_q[$];
  logic [31:0] got_q[$];
  int          fire_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic cf, rf;
    cmd_t c, e;
    logic [31:0] rd;
    logic [2:0] ro;
    cf   = bus.cmd_valid && bus.cmd_ready;
    rf   = bus.res_valid && bus.res_ready;
    c.op = bus.cmd_op;
    c.a  = bus.cmd_a;
    c.b  = bus.cmd_b;
    rd   = bus.res_data;
    ro   = bus.res_op;
    @(posedge clk);
    #1;
    cyc++;
    if (cf) begin
      exp_q.push_back(c);
      if (send_q.size() > 0) send_q.delete(0);
    end
    if (rf) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'(rd), 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("res_data", 64'(rd), 64'(ref_alu(e.op, e.a, e.b)));
        check("res_op", 64'(ro), 64'(e.op));
      end
      got_q.push_back(rd);
      fire_q.push_back(cyc);
    end
  endtask

  task automatic drive_front();
    bus.cmd_valid = (send_q.size() > 0);
    if (send_q.size() > 0) begin
      bus.cmd_op = send_q[0].op;
      bus.cmd_a  = send_q[0].a;
      bus.cmd_b  = send_q[0].b;
    end
  endtask

  // mode 0: res_ready held high; mode 1: res_ready random each cycle
  task automatic drain(input int mode, input int budget);
    int n = 0;
    while ((send_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      drive_front();
      bus.res_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      n++;
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b0;
    if (n >= budget) check("drain_timeout", 64'(send_q.size() + exp_q.size()), 64'd0);
  endtask

  function automatic cmd_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    cmd_t c;
    c.op = op;
    c.a  = a;
    c.b  = b;
    return c;
  endfunction

  initial begin
    logic [31:0] exp8 [8] = '{32'd31, 32'd45, 32'd20, 32'd7, 32'd0, 32'd0, 32'd1, 32'd0};
    logic [31:0] first_res;
    int accepted;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_fifo_count", 64'(bus.fifo_count), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_alu_op", 64'(bus.alu_op), 64'd0);
    check("rst_alu_ab", 64'({bus.alu_a, bus.alu_b}), 64'd0);
    check("rst_res_data", 64'(bus.res_data), 64'd0);
    check("rst_res_op", 64'(bus.res_op), 64'd0);

    // Single add with latency checks
    got_q.delete();
    bus.res_ready = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'd1; bus.cmd_a = 32'd21; bus.cmd_b = 32'd10;
    step();
    bus.cmd_valid = 1'b0;
    step();
    check("lat_alu_a", 64'(bus.alu_a), 64'd21);
    check("lat_alu_b", 64'(bus.alu_b), 64'd10);
    check("lat_alu_op", 64'(bus.alu_op), 64'd1);
    check("lat_res_valid_early", 64'(bus.res_valid), 64'd0);
    step();
    check("lat_res_valid", 64'(bus.res_valid), 64'd1);
    check("lat_res_data", 64'(bus.res_data), 64'd31);
    check("lat_res_op", 64'(bus.res_op), 64'd1);
    drain(0, 20);
    check("single_count", 64'(got_q.size()), 64'd1);

    // Back-to-back stream of all opcodes
    got_q.delete();
    fire_q.delete();
    send_q.push_back(mk(3'd1, 32'd21, 32'd10));
    send_q.push_back(mk(3'd2, 32'd54, 32'd9));
    send_q.push_back(mk(3'd3, 32'd10, $urandom));
    send_q.push_back(mk(3'd4, 32'd15, $urandom));
    send_q.push_back(mk(3'd0, $urandom, $urandom));
    send_q.push_back(mk(3'd5, 32'd1, 32'd0));
    send_q.push_back(mk(3'd6, 32'd0, 32'd1));
    send_q.push_back(mk(3'd7, 32'd1, 32'd1));
    drain(0, 60);
    check("stream_count", 64'(got_q.size()), 64'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) check($sformatf("stream_res%0d", i), 64'(got_q[i]), 64'(exp8[i]));
    for (int i = 1; i < fire_q.size(); i++) check($sformatf("stream_gap%0d", i), 64'(fire_q[i] - fire_q[i-1]), 64'd2);

    // Fill with backpressure
    got_q.delete();
    for (int i = 0; i < 6; i++) send_q.push_back(mk(3'($urandom_range(1, 7)), $urandom, $urandom));
    bus.res_ready = 1'b0;
    first_res = ref_alu(send_q[0].op, send_q[0].a, send_q[0].b);
    for (int c = 0; c < 12; c++) begin
      drive_front();
      step();
      if (bus.res_valid) check("hold_stable", 64'(bus.res_data), 64'(first_res));
    end
    accepted = 6 - send_q.size();
    check("fill_accepted", 64'(accepted), 64'd5);
    check("fill_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("fill_fifo_count", 64'(bus.fifo_count), 64'd4);
    check("fill_busy", 64'(bus.busy), 64'd1);
    send_q.delete();
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    step();
    check("fill_ready_back", 64'(bus.cmd_ready), 64'd1);
    drain(0, 40);
    check("fill_results", 64'(got_q.size()), 64'd5);

    // Pointer wrap with random backpressure
    got_q.delete();
    for (int i = 0; i < 10; i++) send_q.push_back(mk(3'd1, 32'(i), 32'd100));
    drain(1, 400);
    check("wrap_count", 64'(got_q.size()), 64'd10);
    for (int i = 0; i < 10 && i < got_q.size(); i++) check($sformatf("wrap_res%0d", i), 64'(got_q[i]), 64'(100 + i));

    // Arithmetic wrap edges
    got_q.delete();
    send_q.push_back(mk(3'd2, 32'd0, 32'd1));
    send_q.push_back(mk(3'd1, 32'hFFFF_FFFF, 32'd1));
    drain(0, 30);
    check("edge_count", 64'(got_q.size()), 64'd2);
    if (got_q.size() >= 2) begin
      check("edge_sub", 64'(got_q[0]), 64'hFFFF_FFFF);
      check("edge_add", 64'(got_q[1]), 64'd0);
    end

    // Reset while one command is in WAIT and three are queued
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op = 3'd1; bus.cmd_a = 32'(i); bus.cmd_b = 32'd7;
      step();
    end
    bus.res_ready = 1'b1;
    bus.cmd_op = 3'd7; bus.cmd_a = 32'd5; bus.cmd_b = 32'd3;
    step();
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b0;
    check("pre_rst_count", 64'(bus.fifo_count), 64'd3);
    check("pre_rst_busy", 64'(bus.busy), 64'd1);
    check("pre_rst_wait", 64'(bus.res_valid), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("async_res_valid", 64'(bus.res_valid), 64'd0);
    check("async_fifo_count", 64'(bus.fifo_count), 64'd0);
    check("async_alu_op", 64'(bus.alu_op), 64'd0);
    check("async_busy", 64'(bus.busy), 64'd0);
    check("async_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    send_q.push_back(mk(3'd6, 32'd0, 32'd1));
    drain(0, 30);
    check("post_rst_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() >= 1) check("post_rst_res", 64'(got_q[0]), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=%0d expected=finished", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Synthesizable initiator for the 32-bit ALU. It accepts operation commands (opcode plus two operands) over a valid/ready handshake and buffers them in a small FIFO. It issues each command to the combinational ALU through registered operand/opcode outputs, captures the ALU result, and presents it on a valid/ready result port. The block replaces hand-driven stimulus: any upstream master can stream ALU work, and any downstream consumer can drain results at its own pace.

## Interface
- WIDTH, 32, operand/result width; must match the ALU.
- DEPTH, 4, command FIFO entries; power of two, ≥2.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; high when fifo count < DEPTH.
- cmd_op  in  3  opcode: 000 clear, 001 add, 010 sub, 011 shift-left, 100 shift-right, 101 AND, 110 OR, 111 XOR.
- cmd_a, cmd_b  in  WIDTH  operands.
- alu_op  out  3  registered opcode to ALU.
- alu_a, alu_b  out  WIDTH  registered operands to ALU.
- alu_out  in  WIDTH  combinational ALU result.
- res_valid  out  1  result held on res_data.
- res_ready  in  1  consumer accepts result.
- res_data  out  WIDTH  captured result.
- res_op  out  3  opcode that produced res_data.
- fifo_count  out  clog2(DEPTH)+1  entries buffered, excluding the one in flight.
- busy  out  1  high in any state other than IDLE.

## Operation
- FIFO:
  - Circular buffer with wr_ptr/rd_ptr modulo DEPTH; pointers wrap silently.
  - Push on cmd_valid && cmd_ready. Pop only by the FSM.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - cmd_ready depends only on registered fifo_count. A pop in the same cycle does not allow a push when full.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE: if fifo_count≠0, pop head into alu_op/alu_a/alu_b, go to WAIT. Otherwise stay; alu_* hold their last values.
  - WAIT: the ALU settles for one full cycle. At the next edge, res_data←alu_out, res_op←alu_op, res_valid←1, go to HOLD.
  - HOLD: res_valid=1; res_data and res_op are stable. On res_valid && res_ready:
    - res_valid←0.
    - If fifo_count≠0, pop the next command into alu_* in the same edge and go to WAIT.
    - Otherwise go to IDLE.
- ALU semantics the bench checks against (connected ALU):
  - add/sub are modulo 2^WIDTH with no carry/borrow out.
  - Shifts are logical by 1 bit on alu_a.
  - AND/OR/XOR are bitwise a op b.
  - Clear yields 0.
- Capacity: DEPTH buffered commands plus one in flight. With res_ready low from reset, DEPTH+1 commands are accepted before cmd_ready falls.
- Commands are issued strictly in arrival order; there is no reordering and no drop.

## Timing
- Reset (async assert, released synchronously by the clock):
  - State IDLE; pointers and fifo_count 0; cmd_ready 1.
  - alu_op 000; alu_a and alu_b 0.
  - res_valid 0; res_data 0; res_op 000; busy 0.
- Reset asserted mid-operation:
  - Buffered commands and the in-flight command are discarded.
  - Outputs take reset values immediately, without waiting for a clock edge.
- Latency, empty and IDLE: command accepted at edge k → alu_* valid after k+1 → res_valid high after edge k+2.
- Throughput with res_ready held high: one result every 2 cycles. res_valid is high for exactly 1 cycle per result.
- Backpressure: res_ready low holds HOLD indefinitely. res_data and res_op are unchanged; the FIFO keeps accepting until full.
- res_ready asserted while res_valid is low is ignored.

## Test plan
- Single add: cmd (001, a=21, b=10), res_ready=1.
  - Expect alu_a=21, alu_b=10 one cycle after accept.
  - Expect res_valid and res_data=31, res_op=001 two cycles after accept.
- Stream of 8 ops, back-to-back cmd_valid, res_ready=1: (001,21,10), (010,54,9), (011,10,x), (100,15,x), (000,x,x), (101,1,0), (110,0,1), (111,1,1).
  - Expect results in order: 31, 45, 20, 7, 0, 0, 1, 0.
  - Expect one result per 2 cycles.
- Fill/backpressure: res_ready=0, offer 6 commands.
  - Expect exactly 5 accepted, then cmd_ready=0 and fifo_count=4.
  - Expect res_data stable at the first result throughout.
  - Then res_ready=1: expect 5 results in order; cmd_ready reasserts after the first pop.
- Wrap-around: 10 sequential add commands (a=i, b=100), res_ready toggled randomly.
  - Expect results 100..109 in order, with no loss or duplication across pointer wraps.
- Arithmetic edge: sub (010, a=0, b=1) → 0xFFFFFFFF. Add (001, 0xFFFFFFFF, 1) → 0.
- Reset mid-op: 3 commands queued and one in WAIT; assert rst between edges.
  - Expect res_valid=0, fifo_count=0, and alu_op=000 immediately.
  - After release, a new command (110, 0, 1) → result 1.
